// File: rtl/matrix_mac_fsm_if.sv
// rtl/matrix_mac_fsm_if.sv - button, toggle-bank and result bus of the matrix MAC sequencer
interface matrix_mac_fsm_if #(
  parameter int DIM = 2,
  parameter int EW  = 4,
  parameter int CW  = 2*EW + $clog2(DIM)
);
  logic                    load_btn;
  logic                    start_btn;
  logic                    clear_btn;
  logic [DIM*DIM*EW-1:0]   switches;
  logic [DIM*DIM*EW-1:0]   mat_a;
  logic [DIM*DIM*EW-1:0]   mat_b;
  logic [DIM*DIM*CW-1:0]   mat_c;
  logic                    load_pulse_out;
  logic                    busy;
  logic                    active;
  logic [2:0]              state_o;

  // driver side: buttons and toggle bank
  modport master (
    output load_btn, start_btn, clear_btn, switches,
    input  mat_a, mat_b, mat_c, load_pulse_out, busy, active, state_o
  );

  // sequencer side
  modport slave (
    input  load_btn, start_btn, clear_btn, switches,
    output mat_a, mat_b, mat_c, load_pulse_out, busy, active, state_o
  );
endinterface

// File: rtl/matrix_mac_fsm.sv
// rtl/matrix_mac_fsm.sv - loads A and B from toggles, computes C = A x B on one sequential MAC
module matrix_mac_fsm #(
  parameter int DIM = 2,
  parameter int EW  = 4,
  parameter int CW  = 2*EW + $clog2(DIM)
) (
  input  logic            clk,
  input  logic            RST,
  matrix_mac_fsm_if.slave bus
);
  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] IMAX = IW'(DIM-1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_READY  = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // bit0/bit1 form the synchroniser, bit2 is the edge-detect history
  logic [2:0] ld_s, st_s, cl_s;
  logic       ld_p, st_p, cl_p;

  logic [EW-1:0] sw_el [DIM][DIM];
  logic [EW-1:0] a_m   [DIM][DIM];
  logic [EW-1:0] b_m   [DIM][DIM];
  logic [CW-1:0] c_m   [DIM][DIM];
  logic [CW-1:0] acc_q;
  logic [IW-1:0] i_q, j_q, k_q;
  logic [2*EW-1:0] prod;
  logic          last_mac;
  logic          lp_q;

  // synchronise the raw buttons and keep one cycle of history for edge detection
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ld_s <= '0;
      st_s <= '0;
      cl_s <= '0;
    end else begin
      ld_s <= {ld_s[1:0], bus.load_btn};
      st_s <= {st_s[1:0], bus.start_btn};
      cl_s <= {cl_s[1:0], bus.clear_btn};
    end
  end

  assign ld_p = ld_s[1] & ~ld_s[2];
  assign st_p = st_s[1] & ~st_s[2];
  assign cl_p = cl_s[1] & ~cl_s[2];

  assign prod     = a_m[i_q][k_q] * b_m[k_q][j_q];
  assign last_mac = (i_q == IMAX) && (j_q == IMAX) && (k_q == IMAX);

  // row-major packing: element (0,0) sits in the top field
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      localparam int F = DIM*DIM - 1 - (r*DIM + c);
      assign sw_el[r][c]              = bus.switches[F*EW +: EW];
      assign bus.mat_a[F*EW +: EW]    = a_m[r][c];
      assign bus.mat_b[F*EW +: EW]    = b_m[r][c];
      assign bus.mat_c[F*CW +: CW]    = c_m[r][c];
    end
  end

  assign bus.load_pulse_out = lp_q;

  // state register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state: clear beats load beats start; ignored events simply leave the state alone
  always_comb begin
    state_d = state_q;
    if (cl_p) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (ld_p) state_d = S_LOAD_B;
        S_LOAD_B: if (ld_p) state_d = S_READY;
        S_READY:  if (st_p) state_d = S_CALC;
        S_CALC:   if (last_mac) state_d = S_DONE;
        S_DONE: begin
          if (ld_p)      state_d = S_LOAD_B;
          else if (st_p) state_d = S_CALC;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // status outputs decoded straight from the state register
  always_comb begin
    bus.busy    = (state_q == S_CALC);
    bus.active  = (state_q == S_DONE);
    bus.state_o = state_q;
  end

  // matrix capture and the MAC walk over i, j, k (k innermost)
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      a_m   <= '{default: '0};
      b_m   <= '{default: '0};
      c_m   <= '{default: '0};
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      lp_q  <= 1'b0;
    end else begin
      lp_q <= 1'b0;
      if (cl_p) begin
        a_m   <= '{default: '0};
        b_m   <= '{default: '0};
        c_m   <= '{default: '0};
        acc_q <= '0;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (ld_p) begin
            a_m  <= sw_el;
            lp_q <= 1'b1;
          end
          S_LOAD_B: if (ld_p) begin
            b_m  <= sw_el;
            lp_q <= 1'b1;
          end
          S_CALC: begin
            if (k_q == IMAX) begin
              c_m[i_q][j_q] <= acc_q + CW'(prod);
              acc_q <= '0;
              k_q   <= '0;
              if (j_q == IMAX) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
              end else begin
                j_q <= j_q + 1'b1;
              end
            end else begin
              acc_q <= acc_q + CW'(prod);
              k_q   <= k_q + 1'b1;
            end
          end
          S_READY, S_DONE: begin
            if (state_q == S_DONE && ld_p) begin
              a_m  <= sw_el;
              lp_q <= 1'b1;
            end else if (st_p) begin
              c_m   <= '{default: '0};
              acc_q <= '0;
              i_q   <= '0;
              j_q   <= '0;
              k_q   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matrix_mac_fsm.sv
// tb/tb_matrix_mac_fsm.sv - randomized self-checking bench for matrix_mac_fsm
module tb_matrix_mac_fsm;
  localparam int DIM = 2;
  localparam int EW  = 4;
  localparam int CW  = 9;
  localparam int N   = DIM*DIM;
  localparam int AW  = N*EW;
  localparam int CWW = N*CW;

  logic clk = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lp_count = 0;

  matrix_mac_fsm_if #(.DIM(DIM), .EW(EW), .CW(CW)) bus ();

  matrix_mac_fsm #(.DIM(DIM), .EW(EW), .CW(CW)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.load_pulse_out === 1'b1) lp_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // C = A x B from the matrix definition, on plain integers
  function automatic logic [CWW-1:0] ref_mul(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [CWW-1:0] res;
    logic [AW-1:0]  t;
    int s, ea, eb;
    res = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        s = 0;
        for (int k = 0; k < DIM; k++) begin
          t  = a >> (EW*(N-1-(r*DIM+k)));
          ea = int'(t[EW-1:0]);
          t  = b >> (EW*(N-1-(k*DIM+c)));
          eb = int'(t[EW-1:0]);
          s  = s + ea*eb;
        end
        res = res | (CWW'(s) << (CW*(N-1-(r*DIM+c))));
      end
    end
    return res;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bit0 = load, bit1 = start, bit2 = clear
  task automatic press(input int mask);
    @(negedge clk);
    bus.load_btn  = mask[0];
    bus.start_btn = mask[1];
    bus.clear_btn = mask[2];
    cycles($urandom_range(1, 3));
    bus.load_btn  = 1'b0;
    bus.start_btn = 1'b0;
    bus.clear_btn = 1'b0;
    cycles(4);
  endtask

  task automatic load(input logic [AW-1:0] w);
    bus.switches = w;
    press(1);
    bus.switches = AW'($urandom);
  endtask

  // one-cycle start press, then watch a fixed window counting busy cycles
  task automatic run_start(output int busy_cycles, output bit done_ok);
    @(negedge clk);
    bus.start_btn = 1'b1;
    busy_cycles = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      bus.start_btn = 1'b0;
      if (bus.busy === 1'b1) busy_cycles++;
    end
    done_ok = (bus.state_o === 3'd4) && (bus.active === 1'b1) && (bus.busy === 1'b0);
  endtask

  task automatic do_reset;
    bus.load_btn  = 1'b0;
    bus.start_btn = 1'b0;
    bus.clear_btn = 1'b0;
    bus.switches  = '0;
    RST = 1'b1;
    cycles(2);
    RST = 1'b0;
    cycles(2);
  endtask

  task automatic test_reset;
    load(16'hABCD);
    @(negedge clk);
    #1 RST = 1'b1;
    #1;
    n_checks++;
    if (bus.state_o !== 3'd0 || bus.busy !== 1'b0 || bus.active !== 1'b0 || bus.load_pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: state=%0d busy=%b active=%b lp=%b want 0 0 0 0",
               bus.state_o, bus.busy, bus.active, bus.load_pulse_out);
    end
    n_checks++;
    if (bus.mat_a !== '0 || bus.mat_b !== '0 || bus.mat_c !== '0) begin
      n_fail++;
      $display("FAIL reset_mats: a=%h b=%h c=%h want all 0", bus.mat_a, bus.mat_b, bus.mat_c);
    end
    @(negedge clk);
    RST = 1'b0;
    cycles(2);
  endtask

  task automatic test_ignore_start_idle;
    press(2);
    cycles(4);
    n_checks++;
    if (bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_start_ignored: state=%0d busy=%b want 0 0", bus.state_o, bus.busy);
    end
  endtask

  task automatic test_load_compute;
    int lp0, bc;
    bit ok;
    lp0 = lp_count;
    load(16'h1234);
    n_checks++;
    if (bus.mat_a !== 16'h1234 || bus.state_o !== 3'd1) begin
      n_fail++;
      $display("FAIL load_a: a=%h state=%0d want 1234 1", bus.mat_a, bus.state_o);
    end
    load(16'h5678);
    n_checks++;
    if (bus.mat_b !== 16'h5678 || bus.state_o !== 3'd2) begin
      n_fail++;
      $display("FAIL load_b: b=%h state=%0d want 5678 2", bus.mat_b, bus.state_o);
    end
    // a load in READY must neither capture nor pulse
    load(16'h9999);
    n_checks++;
    if (bus.state_o !== 3'd2 || bus.mat_a !== 16'h1234 || bus.mat_b !== 16'h5678) begin
      n_fail++;
      $display("FAIL ready_load_ignored: state=%0d a=%h b=%h want 2 1234 5678",
               bus.state_o, bus.mat_a, bus.mat_b);
    end
    run_start(bc, ok);
    n_checks++;
    if (bc !== DIM*DIM*DIM) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d want %0d", bc, DIM*DIM*DIM);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_state: state=%0d active=%b want 4 1", bus.state_o, bus.active);
    end
    n_checks++;
    if (bus.mat_c !== {9'd19, 9'd22, 9'd43, 9'd50}) begin
      n_fail++;
      $display("FAIL product_1234_5678: got %h want %h", bus.mat_c, {9'd19, 9'd22, 9'd43, 9'd50});
    end
    n_checks++;
    if (lp_count - lp0 !== 2) begin
      n_fail++;
      $display("FAIL load_pulse_count: got %0d want 2", lp_count - lp0);
    end
  endtask

  task automatic test_ignored_in_calc;
    int lp0, t;
    lp0 = lp_count;
    bus.switches = 16'hEEEE;
    @(negedge clk);
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.start_btn = 1'b0;
    t = 0;
    while (bus.busy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL calc_entry_timeout: busy=%b want 1", bus.busy);
    end
    bus.load_btn  = 1'b1;
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.load_btn  = 1'b0;
    bus.start_btn = 1'b0;
    cycles(30);
    n_checks++;
    if (bus.state_o !== 3'd4 || bus.mat_a !== 16'h1234) begin
      n_fail++;
      $display("FAIL calc_events_ignored: state=%0d a=%h want 4 1234", bus.state_o, bus.mat_a);
    end
    n_checks++;
    if (lp_count !== lp0) begin
      n_fail++;
      $display("FAIL calc_no_load_pulse: got %0d pulses want 0", lp_count - lp0);
    end
    n_checks++;
    if (bus.mat_c !== {9'd19, 9'd22, 9'd43, 9'd50}) begin
      n_fail++;
      $display("FAIL calc_result_kept: got %h want %h", bus.mat_c, {9'd19, 9'd22, 9'd43, 9'd50});
    end
  endtask

  task automatic test_reload_in_done;
    logic [CWW-1:0] old_c;
    old_c = bus.mat_c;
    load(16'h1000);
    n_checks++;
    if (bus.state_o !== 3'd1 || bus.mat_a !== 16'h1000 || bus.mat_c !== old_c) begin
      n_fail++;
      $display("FAIL done_reload: state=%0d a=%h c=%h want 1 1000 %h",
               bus.state_o, bus.mat_a, bus.mat_c, old_c);
    end
  endtask

  task automatic test_clear_and_load;
    int lp0, bc;
    bit ok;
    load(16'h1234);
    load(16'h5678);
    run_start(bc, ok);
    lp0 = lp_count;
    bus.switches = 16'h4321;
    press(5);
    n_checks++;
    if (bus.state_o !== 3'd0 || bus.mat_a !== '0 || bus.mat_b !== '0 || bus.mat_c !== '0) begin
      n_fail++;
      $display("FAIL clear_over_load: state=%0d a=%h b=%h c=%h want 0 0 0 0",
               bus.state_o, bus.mat_a, bus.mat_b, bus.mat_c);
    end
    n_checks++;
    if (lp_count !== lp0) begin
      n_fail++;
      $display("FAIL clear_no_load_pulse: got %0d pulses want 0", lp_count - lp0);
    end
  endtask

  task automatic test_max_values;
    int bc;
    bit ok;
    load(16'hFFFF);
    load(16'hFFFF);
    run_start(bc, ok);
    n_checks++;
    if (!ok || bus.mat_c !== {4{9'd450}}) begin
      n_fail++;
      $display("FAIL max_values: ok=%b c=%h want 1 %h", ok, bus.mat_c, {4{9'd450}});
    end
    press(4);
  endtask

  task automatic test_random;
    logic [AW-1:0] a, b;
    int bc;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      a = AW'($urandom);
      b = AW'($urandom);
      load(a);
      load(b);
      run_start(bc, ok);
      n_checks++;
      if (!ok || bc !== DIM*DIM*DIM || bus.mat_c !== ref_mul(a, b)) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h ok=%b busy=%0d c=%h want %h",
                 it, a, b, ok, bc, bus.mat_c, ref_mul(a, b));
      end
      // recompute from DONE with the same operands must give the same C
      run_start(bc, ok);
      n_checks++;
      if (!ok || bus.mat_c !== ref_mul(a, b)) begin
        n_fail++;
        $display("FAIL recompute_%0d: c=%h want %h", it, bus.mat_c, ref_mul(a, b));
      end
      press(4);
    end
  endtask

  task automatic test_abort;
    int t, bc;
    bit ok;
    load(16'h1234);
    load(16'h5678);
    @(negedge clk);
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.start_btn = 1'b0;
    t = 0;
    while (bus.busy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    cycles(3);
    #1 RST = 1'b1;
    #1;
    n_checks++;
    if (bus.state_o !== 3'd0 || bus.busy !== 1'b0 || bus.mat_c !== '0) begin
      n_fail++;
      $display("FAIL abort_mid_calc: state=%0d busy=%b c=%h want 0 0 0", bus.state_o, bus.busy, bus.mat_c);
    end
    @(negedge clk);
    RST = 1'b0;
    cycles(2);
    load(16'h1234);
    load(16'h5678);
    run_start(bc, ok);
    n_checks++;
    if (!ok || bus.mat_c !== {9'd19, 9'd22, 9'd43, 9'd50}) begin
      n_fail++;
      $display("FAIL abort_recovery: ok=%b c=%h want 1 %h", ok, bus.mat_c, {9'd19, 9'd22, 9'd43, 9'd50});
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_ignore_start_idle();
    test_load_compute();
    test_ignored_in_calc();
    test_reload_in_done();
    do_reset();
    test_clear_and_load();
    test_max_values();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
